pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 89 ++++++++
 tb/tb_pipe_skid_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid buffer pipeline stage
// in_ready is decoded from registered state only, so out_ready never reaches it combinationally.
module pipe_skid_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (in_valid) begin
            r_main  <= in_data;
            r_state <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_valid && out_ready) begin
            r_main <= in_data;
          end else if (in_valid) begin
            r_skid  <= in_data;
            r_state <= ST_FULL;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_main  <= r_skid;
            r_state <= ST_HALF;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        in_ready = 1'b1;
      end
      ST_HALF: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign out_data = r_main;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed and randomized checks against a two-slot FIFO model
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] q[$];

  pipe_skid_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Expected outputs come from the FIFO contents: capacity two, head is visible on out_data.
  task automatic check_outputs();
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    if (q.size() > 0) check("out_data", out_data, q[0]);
  endtask

  task automatic model_edge();
    bit do_pop;
    bit do_push;
    if (reset || flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && out_ready;
      do_push = in_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    model_edge();
    #1;
    reset = 1'b0;

    // reset then idle
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    cycle();
    cycle();

    // streaming at full rate
    drive(1'b1, 32'h1, 1'b1); cycle();
    check("stream_1", out_data, 32'h1);
    drive(1'b1, 32'h2, 1'b1); cycle();
    check("stream_2", out_data, 32'h2);
    drive(1'b1, 32'h3, 1'b1); cycle();
    check("stream_3", out_data, 32'h3);
    drive(1'b0, 32'h0, 1'b1); cycle();
    cycle();

    // backpressure fills the skid register
    drive(1'b1, 32'hA, 1'b0); cycle();
    check("bp_occ1", 32'(occupancy), 32'h1);
    drive(1'b1, 32'hB, 1'b0); cycle();
    check("bp_occ2", 32'(occupancy), 32'h2);
    check("bp_hold_A", out_data, 32'hA);
    drive(1'b0, 32'h0, 1'b0); cycle();
    check("bp_stable_A", out_data, 32'hA);
    drive(1'b0, 32'h0, 1'b1); cycle();
    check("bp_drain_B", out_data, 32'hB);
    cycle();
    check("bp_empty", 32'(out_valid), 32'h0);

    // word offered while full is not accepted
    drive(1'b1, 32'h5, 1'b0); cycle();
    drive(1'b1, 32'h6, 1'b0); cycle();
    drive(1'b1, 32'hC, 1'b0); cycle();
    check("full_rej_head", out_data, 32'h5);
    drive(1'b0, 32'h0, 1'b1); cycle();
    check("full_rej_next", out_data, 32'h6);
    cycle();
    check("full_rej_empty", 32'(out_valid), 32'h0);
    cycle();

    // flush while full with a word offered
    drive(1'b1, 32'h7, 1'b0); cycle();
    drive(1'b1, 32'h8, 1'b0); cycle();
    flush = 1'b1;
    drive(1'b1, 32'hD, 1'b0); cycle();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    check("flush_occ", 32'(occupancy), 32'h0);
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_ready", 32'(in_ready), 32'h1);
    cycle();
    cycle();

    // reset in HALF with transfers and flush also requested
    drive(1'b1, 32'h9, 1'b0); cycle();
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 32'hE, 1'b1); cycle();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    check("rst_mid_data", out_data, 32'h0);
    check("rst_mid_occ", 32'(occupancy), 32'h0);
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 79) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
      cycle();
    end
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
